// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional misaligned-redirect trap: FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    DROP,
    HALT
  } fetch_state_e;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          PC_INC       = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two ring with sync clear and count.
// Head word is read straight from registered storage.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem requests, prefetch FIFO.
// FETCH_ALIGN_CHECK_EN: misaligned redirect traps into HALT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               inst_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rpc;
  logic              push, pop, clr;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign rpc = redirect_pc;
`else
  assign rpc = redirect_pc & ~ADDR_W'(3);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    if (redirect_valid && state_q != HALT) begin
      clr = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      if (|redirect_pc[1:0]) begin
        fault_d = 1'b1;
        state_d = HALT;
      end else
`endif
      begin
        pc_d = rpc;
        // An unanswered request must still complete; its data is dropped.
        if (state_q != RUN && !imem_ack) begin
          state_d = DROP;
        end else begin
          state_d = WAIT;
          addr_d  = rpc;
        end
      end
    end else begin
      pop = inst_valid && inst_ready;
      unique case (state_q)
        RUN: begin
          if (cnt < CW'(FIFO_DEPTH)) begin
            state_d = WAIT;
            addr_d  = pc_q;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            push    = 1'b1;
            pc_d    = pc_q + ADDR_W'(PC_INC);
            state_d = RUN;
          end
        end
        DROP: begin
          if (imem_ack) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_d;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata ({addr_q, imem_rdata}),
    .rdata (head),
    .count (cnt)
  );

  assign imem_req   = (state_q == WAIT) || (state_q == DROP);
  assign imem_addr  = addr_q;
  assign inst_valid = (cnt != '0);
  assign {inst_pc, inst_data} = head;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: table of per-cycle
// stimulus/expectations plus hand sequences for reset, credit, faults.
module tb_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int n_vec  = 0;
  int n_err  = 0;
  int n_acks = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_data;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(
    input logic ack, input logic [31:0] rdata, input logic rdy,
    input logic rv, input logic [31:0] rpc, input logic e_req,
    input logic [31:0] e_addr, input logic e_val,
    input logic [31:0] e_data, input logic [31:0] e_pc);
    vec_t v;
    v.ack = ack;     v.rdata = rdata; v.rdy = rdy;
    v.rv = rv;       v.rpc = rpc;     v.e_req = e_req;
    v.e_addr = e_addr; v.e_val = e_val;
    v.e_data = e_data; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory model: acks in the same cycle a request is visible.
  task automatic step(input logic rdy, input logic rv,
                      input logic [31:0] rpc);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = imem_req;
    imem_rdata     = word(imem_addr);
    if (imem_req) n_acks++;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0, 32'h0,         1, 0, 32'h0,   1, 32'h0,   0, 32'h0, 32'h0);
    tbl[1]  = mk(1, 32'hC0DE_0000, 1, 0, 32'h0,   0, 32'h0,   1, 32'hC0DE_0000, 32'h0);
    tbl[2]  = mk(0, 32'h0,         1, 0, 32'h0,   1, 32'h4,   0, 32'h0, 32'h0);
    tbl[3]  = mk(1, 32'hC0DE_0004, 1, 0, 32'h0,   0, 32'h4,   1, 32'hC0DE_0004, 32'h4);
    tbl[4]  = mk(0, 32'h0,         1, 0, 32'h0,   1, 32'h8,   0, 32'h0, 32'h0);
    tbl[5]  = mk(1, 32'hC0DE_0008, 1, 0, 32'h0,   0, 32'h8,   1, 32'hC0DE_0008, 32'h8);
    tbl[6]  = mk(0, 32'h0,         1, 0, 32'h0,   1, 32'hC,   0, 32'h0, 32'h0);
    tbl[7]  = mk(0, 32'h0,         1, 1, 32'h100, 1, 32'hC,   0, 32'h0, 32'h0);
    tbl[8]  = mk(0, 32'h0,         1, 0, 32'h0,   1, 32'hC,   0, 32'h0, 32'h0);
    tbl[9]  = mk(0, 32'h0,         1, 0, 32'h0,   1, 32'hC,   0, 32'h0, 32'h0);
    tbl[10] = mk(1, 32'hDEAD_BEEF, 1, 0, 32'h0,   0, 32'hC,   0, 32'h0, 32'h0);
    tbl[11] = mk(0, 32'h0,         1, 0, 32'h0,   1, 32'h100, 0, 32'h0, 32'h0);
    tbl[12] = mk(1, 32'hC0DE_0100, 1, 0, 32'h0,   0, 32'h100, 1, 32'hC0DE_0100, 32'h100);
    tbl[13] = mk(0, 32'h0,         0, 0, 32'h0,   1, 32'h104, 1, 32'hC0DE_0100, 32'h100);
    tbl[14] = mk(1, 32'hDEAD_BEEF, 1, 1, 32'h200, 1, 32'h200, 0, 32'h0, 32'h0);
    tbl[15] = mk(1, 32'hC0DE_0200, 1, 0, 32'h0,   0, 32'h200, 1, 32'hC0DE_0200, 32'h200);
    tbl[16] = mk(0, 32'h0,         1, 0, 32'h0,   1, 32'h204, 0, 32'h0, 32'h0);
    tbl[17] = mk(0, 32'h0,         1, 1, 32'h300, 1, 32'h204, 0, 32'h0, 32'h0);
    tbl[18] = mk(0, 32'h0,         1, 1, 32'h400, 1, 32'h204, 0, 32'h0, 32'h0);
    tbl[19] = mk(1, 32'hDEAD_BEEF, 1, 0, 32'h0,   0, 32'h204, 0, 32'h0, 32'h0);
    tbl[20] = mk(0, 32'h0,         1, 0, 32'h0,   1, 32'h400, 0, 32'h0, 32'h0);
    tbl[21] = mk(1, 32'hC0DE_0400, 1, 0, 32'h0,   0, 32'h400, 1, 32'hC0DE_0400, 32'h400);

    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_req",   {31'b0, imem_req},    32'h0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_valid", {31'b0, inst_valid},  32'h0);
    chk("rst_data",  inst_data,            32'h0);
    chk("rst_pc",    inst_pc,              32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      imem_ack       = tbl[i].ack;
      imem_rdata     = tbl[i].rdata;
      inst_ready     = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      @(posedge clk); #1;
      chk($sformatf("v%0d_req", i),   {31'b0, imem_req},   {31'b0, tbl[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr,           tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_val});
      chk($sformatf("v%0d_fault", i), {31'b0, fetch_fault}, 32'h0);
      if (tbl[i].e_val) begin
        chk($sformatf("v%0d_data", i), inst_data, tbl[i].e_data);
        chk($sformatf("v%0d_pc", i),   inst_pc,   tbl[i].e_pc);
      end
    end
    redirect_valid = 1'b0;
    imem_ack = 1'b0;

    // Reset asserted while a request is outstanding.
    step(1'b0, 1'b0, 32'h0);
    chk("pre_rst_req",  {31'b0, imem_req}, 32'h1);
    chk("pre_rst_addr", imem_addr,         32'h404);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req",   {31'b0, imem_req},   32'h0);
    chk("mid_rst_addr",  imem_addr,           32'h0);
    chk("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("mid_rst_data",  inst_data,           32'h0);
    chk("mid_rst_pc",    inst_pc,             32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    inst_ready = 1'b0;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("stray_req",   {31'b0, imem_req},   32'h1);
    chk("stray_addr",  imem_addr,           32'h0);
    chk("stray_valid", {31'b0, inst_valid}, 32'h0);

    // Credit limit with decode stalled.
    n_acks = 0;
    repeat (20) step(1'b0, 1'b0, 32'h0);
    chk("fill_acks",  n_acks,              32'd4);
    chk("fill_req",   {31'b0, imem_req},   32'h0);
    chk("fill_valid", {31'b0, inst_valid}, 32'h1);
    chk("fill_pc",    inst_pc,             32'h0);
    chk("fill_data",  inst_data,           32'hC0DE_0000);
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4 && !imem_req; i++) step(1'b0, 1'b0, 32'h0);
    chk("resume_req",  {31'b0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr,         32'h10);
    chk("resume_head", inst_pc,           32'h4);

    // Redirect coinciding with ack, then PC wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_req",   {31'b0, imem_req},   32'h1);
    chk("wrap_addr",  imem_addr,           32'hFFFF_FFFC);
    chk("wrap_valid", {31'b0, inst_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_hvalid", {31'b0, inst_valid}, 32'h1);
    chk("wrap_hpc",    inst_pc,             32'hFFFF_FFFC);
    chk("wrap_hdata",  inst_data,           32'hC0DE_FFFC);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_next_req",  {31'b0, imem_req}, 32'h1);
    chk("wrap_next_addr", imem_addr,         32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Misaligned redirect.
    step(1'b0, 1'b1, 32'h102);
    chk("mis_req",   {31'b0, imem_req},    {31'b0, !ALIGN_EN});
    chk("mis_fault", {31'b0, fetch_fault}, {31'b0, ALIGN_EN});
    chk("mis_valid", {31'b0, inst_valid},  32'h0);
`ifndef FETCH_ALIGN_CHECK_EN
    chk("mis_addr", imem_addr, 32'h100);
`endif
    repeat (5) step(1'b0, 1'b0, 32'h0);
    chk("mis_end_req",   {31'b0, imem_req},    32'h0);
    chk("mis_end_fault", {31'b0, fetch_fault}, {31'b0, ALIGN_EN});
    chk("mis_end_valid", {31'b0, inst_valid},  {31'b0, !ALIGN_EN});
`ifndef FETCH_ALIGN_CHECK_EN
    chk("mis_end_pc",   inst_pc,   32'h100);
    chk("mis_end_data", inst_data, 32'hC0DE_0100);
`endif
    #2 rst = 1'b0;
    #1;
    chk("final_fault", {31'b0, fetch_fault}, 32'h0);
    chk("final_valid", {31'b0, inst_valid},  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
